core_run_ctrl: RTL and testbench
================================

// Module: core_run_ctrl
//
// PURPOSE
//  Front-panel run controller for the core pipeline. Turns button pulses
//  (run/stop/step/load-PC) into the core's cpu_exec / pc_wen / microarch-reset
//  controls. Drains in-flight instructions on stop, halt and step, and flushes
//  the pipeline if a drain hangs. Counts retired instructions.
//  Sits between the panel debouncers and core.
//
// PARAMETERS
//  DRAIN_TIMEOUT  64  cycles in DRAIN without cpu_done_i before forcing FLUSH (>=2)
//  FLUSH_CYCLES   4   cycles core_rst_no is held low per FLUSH (>=1)
//  PC_RESET       8'h10  value of pc_o after arst_ni
//
// PORTS
//  clk_i        in   1   clock
//  arst_ni      in   1   async reset, active low
//  run_i        in   1   1-cycle pulse: start free-running execution
//  stop_i       in   1   1-cycle pulse: stop fetch and drain
//  step_i       in   1   1-cycle pulse: execute one instruction
//  load_pc_i    in   1   1-cycle pulse: write sw_addr_i into core PC
//  sw_addr_i    in   8   panel address switches
//  cnt_clr_i    in   1   clear instr_cnt_o
//  cpu_halt_i   in   1   core decoding a HALT
//  cpu_done_i   in   1   core has no in-flight instructions
//  instr_val_i  in   1   core retired one instruction this cycle
//  cpu_exec_o   out  2   to core: 0 fetch off, 1 run, 2 single step
//  pc_wen_o     out  1   to core: manual PC write strobe
//  pc_o         out  8   to core: manual PC value
//  core_rst_no  out  1   to core rst_ni: microarch reset, active low
//  running_o    out  1   state is RUN or STEP
//  halted_o     out  1   state is HALTED
//  cmd_err_o    out  1   1-cycle pulse: command ignored in current state
//  instr_cnt_o  out  16  retired-instruction count
//
// BEHAVIOUR
//  - All outputs are registered. Reset values:
//      cpu_exec_o=0, pc_wen_o=0, pc_o=PC_RESET, core_rst_no=0, running_o=0,
//      halted_o=0, cmd_err_o=0, instr_cnt_o=0. State = FLUSH with a full
//      FLUSH_CYCLES count.
//  - Commands are evaluated only in IDLE and HALTED.
//      Priority: stop > load_pc > step > run. Lower-priority pulses in the same
//      cycle are dropped silently.
//  - Any run/step/load_pc pulse in RUN, STEP, DRAIN or FLUSH -> cmd_err_o=1 next
//    cycle, no other effect. A stop_i in IDLE, HALTED or FLUSH is a no-op (no err).
//  - States (outputs are shown as they appear while in the state):
//    FLUSH:   core_rst_no=0, exec=0. Down-counter runs from FLUSH_CYCLES.
//             At 0 -> IDLE with core_rst_no=1. halted flag cleared.
//    IDLE:    exec=0.
//             run -> RUN. step -> STEP.
//             load_pc -> pc_o<=sw_addr_i and pc_wen_o=1 for exactly one cycle;
//             stay in IDLE.
//    RUN:     exec=1.
//             stop_i -> DRAIN.
//             cpu_halt_i -> DRAIN with halted flag set.
//             If both occur together, the halted flag is still set.
//    STEP:    exec=2 for exactly one cycle, then DRAIN. The core advances the
//             PC on every exec=2 cycle, so exec=2 must never last 2 cycles.
//             cpu_halt_i in this cycle sets the halted flag.
//    DRAIN:   exec=0. Timeout counter cleared on entry.
//             cpu_done_i -> HALTED if the halted flag is set, else IDLE.
//             Counter reaching DRAIN_TIMEOUT-1 without cpu_done_i -> FLUSH.
//             The halted flag is dropped.
//             cpu_halt_i seen during DRAIN also sets the halted flag.
//    HALTED:  exec=0, halted_o=1. Same commands as IDLE.
//             run/step first pass through FLUSH with a 1-cycle core_rst_no low,
//             then go to RUN/STEP (pending target held in a register).
//             load_pc is accepted and does not leave HALTED.
//  - instr_cnt_o: +1 on each instr_val_i cycle, saturating at 16'hFFFF.
//    cnt_clr_i wins over an increment in the same cycle.
//    The count is not cleared by FLUSH; only arst_ni or cnt_clr_i clear it.
//  - arst_ni asserted in any state: immediate return to the reset values above.
//    Pending target and flags are lost.
//
// TESTING
//  1. Release arst_ni. core_rst_no must be 0 for exactly 4 cycles, then 1.
//     State IDLE, cpu_exec_o=0, pc_o=8'h10.
//  2. In IDLE: sw_addr_i=8'h20, pulse load_pc_i -> pc_wen_o=1 for 1 cycle with
//     pc_o=8'h20. Then pulse run_i -> cpu_exec_o=1 and running_o=1 next cycle.
//  3. In RUN: pulse stop_i -> cpu_exec_o=0 next cycle. Assert cpu_done_i 5
//     cycles later -> IDLE. Meanwhile 7 instr_val_i pulses -> instr_cnt_o=7.
//  4. From IDLE: pulse step_i -> cpu_exec_o=2 for exactly 1 cycle, then 0.
//     cpu_done_i -> IDLE. Check step_i arriving during DRAIN -> cmd_err_o pulse.
//  5. In RUN: assert cpu_halt_i -> DRAIN, then HALTED on cpu_done_i (halted_o=1).
//     Pulse run_i -> 1-cycle core_rst_no=0, then RUN with halted_o=0.
//  6. In DRAIN: hold cpu_done_i=0 -> FLUSH entered after 64 cycles.
//     core_rst_no low 4 cycles, then IDLE. Also preload count 16'hFFFE and apply
//     3 instr_val_i pulses -> instr_cnt_o=16'hFFFF.

Source files
------------

// File: rtl/core_run_ctrl.sv
// Front-panel run controller: panel pulses -> core exec / PC write / microarch reset.
// Latency: all outputs registered, one cycle after the causing input or state change.
// Backpressure: none; commands outside IDLE/HALTED are dropped and flagged on cmd_err_o.
`timescale 1ns/1ps
module core_run_ctrl #(
  parameter int unsigned DRAIN_TIMEOUT = 64,
  parameter int unsigned FLUSH_CYCLES  = 4,
  parameter logic [7:0]  PC_RESET      = 8'h10
) (
  input  logic        clk_i,
  input  logic        arst_ni,
  input  logic        run_i,
  input  logic        stop_i,
  input  logic        step_i,
  input  logic        load_pc_i,
  input  logic [7:0]  sw_addr_i,
  input  logic        cnt_clr_i,
  input  logic        cpu_halt_i,
  input  logic        cpu_done_i,
  input  logic        instr_val_i,
  output logic [1:0]  cpu_exec_o,
  output logic        pc_wen_o,
  output logic [7:0]  pc_o,
  output logic        core_rst_no,
  output logic        running_o,
  output logic        halted_o,
  output logic        cmd_err_o,
  output logic [15:0] instr_cnt_o
);

  localparam int unsigned   DW         = $clog2(DRAIN_TIMEOUT);
  localparam int unsigned   FW         = $clog2(FLUSH_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES);
  localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);

  typedef enum logic [2:0] {
    ST_FLUSH, ST_IDLE, ST_RUN, ST_STEP, ST_DRAIN, ST_HALTED
  } state_t;

  typedef enum logic [1:0] {
    TGT_IDLE, TGT_RUN, TGT_STEP
  } tgt_t;

  state_t        state_q, state_d;
  tgt_t          tgt_q, tgt_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          halt_flag_q, halt_flag_d;
  logic          halt_seen;
  logic          cmd_ok;
  logic          pc_load;
  logic          err_d;

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    flush_cnt_d = flush_cnt_q;
    drain_cnt_d = drain_cnt_q;
    halt_flag_d = halt_flag_q;
    halt_seen   = halt_flag_q | cpu_halt_i;
    pc_load     = 1'b0;
    cmd_ok      = (state_q == ST_IDLE) || (state_q == ST_HALTED);
    err_d       = !cmd_ok && (run_i || step_i || load_pc_i);

    case (state_q)
      ST_FLUSH: begin
        // Counter never sits at zero inside FLUSH: leaving on the 1 -> 0 step
        // keeps core_rst_no low for exactly the loaded number of cycles.
        if (flush_cnt_q <= FLUSH_ONE) begin
          halt_flag_d = 1'b0;
          tgt_d       = TGT_IDLE;
          case (tgt_q)
            TGT_RUN:  state_d = ST_RUN;
            TGT_STEP: state_d = ST_STEP;
            default:  state_d = ST_IDLE;
          endcase
        end else begin
          flush_cnt_d = flush_cnt_q - FLUSH_ONE;
        end
      end

      ST_IDLE, ST_HALTED: begin
        if (!stop_i) begin
          if (load_pc_i) begin
            pc_load = 1'b1;
          end else if (step_i || run_i) begin
            if (state_q == ST_IDLE) begin
              state_d = step_i ? ST_STEP : ST_RUN;
            end else begin
              // Leaving HALTED: one-cycle microarch reset, then the held target.
              state_d     = ST_FLUSH;
              flush_cnt_d = FLUSH_ONE;
              tgt_d       = step_i ? TGT_STEP : TGT_RUN;
            end
          end
        end
      end

      ST_RUN: begin
        if (cpu_halt_i) halt_flag_d = 1'b1;
        if (stop_i || cpu_halt_i) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end

      ST_STEP: begin
        if (cpu_halt_i) halt_flag_d = 1'b1;
        state_d     = ST_DRAIN;
        drain_cnt_d = '0;
      end

      ST_DRAIN: begin
        if (cpu_done_i) begin
          state_d     = halt_seen ? ST_HALTED : ST_IDLE;
          halt_flag_d = 1'b0;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_INIT;
          halt_flag_d = 1'b0;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
          halt_flag_d = halt_seen;
        end
      end

      default: begin
        state_d     = ST_FLUSH;
        flush_cnt_d = FLUSH_INIT;
        tgt_d       = TGT_IDLE;
        halt_flag_d = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= ST_FLUSH;
      tgt_q       <= TGT_IDLE;
      flush_cnt_q <= FLUSH_INIT;
      drain_cnt_q <= '0;
      halt_flag_q <= 1'b0;
      cpu_exec_o  <= 2'd0;
      pc_wen_o    <= 1'b0;
      pc_o        <= PC_RESET;
      core_rst_no <= 1'b0;
      running_o   <= 1'b0;
      halted_o    <= 1'b0;
      cmd_err_o   <= 1'b0;
      instr_cnt_o <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      flush_cnt_q <= flush_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      halt_flag_q <= halt_flag_d;

      case (state_d)
        ST_RUN:  cpu_exec_o <= 2'd1;
        ST_STEP: cpu_exec_o <= 2'd2;
        default: cpu_exec_o <= 2'd0;
      endcase
      core_rst_no <= (state_d != ST_FLUSH);
      running_o   <= (state_d == ST_RUN) || (state_d == ST_STEP);
      halted_o    <= (state_d == ST_HALTED);
      cmd_err_o   <= err_d;

      pc_wen_o <= pc_load;
      if (pc_load) pc_o <= sw_addr_i;

      if (cnt_clr_i) begin
        instr_cnt_o <= '0;
      end else if (instr_val_i && (instr_cnt_o != 16'hFFFF)) begin
        instr_cnt_o <= instr_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed vector table, hand sequences, then random traffic vs. a mode-level model.
`timescale 1ns/1ps
module tb_core_run_ctrl;

  localparam int         DRAIN_TIMEOUT = 64;
  localparam int         FLUSH_CYCLES  = 4;
  localparam logic [7:0] PC_RESET      = 8'h10;

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic        run_i, stop_i, step_i, load_pc_i, cnt_clr_i;
  logic        cpu_halt_i, cpu_done_i, instr_val_i;
  logic [7:0]  sw_addr_i;
  logic [1:0]  cpu_exec_o;
  logic        pc_wen_o;
  logic [7:0]  pc_o;
  logic        core_rst_no, running_o, halted_o, cmd_err_o;
  logic [15:0] instr_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  core_run_ctrl #(
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .PC_RESET     (PC_RESET)
  ) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .run_i(run_i), .stop_i(stop_i), .step_i(step_i), .load_pc_i(load_pc_i),
    .sw_addr_i(sw_addr_i), .cnt_clr_i(cnt_clr_i),
    .cpu_halt_i(cpu_halt_i), .cpu_done_i(cpu_done_i), .instr_val_i(instr_val_i),
    .cpu_exec_o(cpu_exec_o), .pc_wen_o(pc_wen_o), .pc_o(pc_o),
    .core_rst_no(core_rst_no), .running_o(running_o), .halted_o(halted_o),
    .cmd_err_o(cmd_err_o), .instr_cnt_o(instr_cnt_o)
  );

  // Packed view: {0, exec[2], wen, pc[8], rst_n, running, halted, err, cnt[16]}
  function automatic logic [31:0] pack(input logic [1:0] ex, input logic wen, input logic [7:0] pc,
                                       input logic rstn, input logic runo, input logic hlt,
                                       input logic err, input logic [15:0] cnt);
    return {1'b0, ex, wen, pc, rstn, runo, hlt, err, cnt};
  endfunction

  function automatic logic [31:0] act_vec();
    return pack(cpu_exec_o, pc_wen_o, pc_o, core_rst_no, running_o, halted_o, cmd_err_o, instr_cnt_o);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    run_i = 0; stop_i = 0; step_i = 0; load_pc_i = 0; cnt_clr_i = 0;
    cpu_halt_i = 0; cpu_done_i = 0; instr_val_i = 0; sw_addr_i = 8'h00;
  endtask

  // Reference model: controller modes by name, with cycle budgets instead of counters.
  string      m_mode, m_after;
  int         m_rst_left, m_age, m_cnt;
  bit         m_hpend, m_wen, m_err;
  logic [7:0] m_pc;

  task automatic model_reset();
    m_mode = "FLUSH"; m_after = "IDLE"; m_rst_left = FLUSH_CYCLES; m_age = 0;
    m_cnt = 0; m_hpend = 0; m_wen = 0; m_err = 0; m_pc = PC_RESET;
  endtask

  task automatic model_step();
    bit cmd;
    cmd   = run_i | step_i | load_pc_i;
    m_wen = 0;
    m_err = 0;
    if (m_mode == "IDLE" || m_mode == "HALTED") begin
      if (!stop_i) begin
        if (load_pc_i) begin
          m_wen = 1;
          m_pc  = sw_addr_i;
        end else if (step_i || run_i) begin
          if (m_mode == "HALTED") begin
            m_after    = step_i ? "STEP" : "RUN";
            m_mode     = "FLUSH";
            m_rst_left = 1;
          end else begin
            m_mode = step_i ? "STEP" : "RUN";
          end
        end
      end
    end else begin
      m_err = cmd;
      if (m_mode == "FLUSH") begin
        m_rst_left--;
        if (m_rst_left == 0) begin
          m_mode = m_after; m_after = "IDLE"; m_hpend = 0;
        end
      end else if (m_mode == "RUN") begin
        if (cpu_halt_i) m_hpend = 1;
        if (stop_i || cpu_halt_i) begin m_mode = "DRAIN"; m_age = 0; end
      end else if (m_mode == "STEP") begin
        if (cpu_halt_i) m_hpend = 1;
        m_mode = "DRAIN"; m_age = 0;
      end else if (m_mode == "DRAIN") begin
        if (cpu_halt_i) m_hpend = 1;
        if (cpu_done_i) begin
          m_mode = m_hpend ? "HALTED" : "IDLE"; m_hpend = 0;
        end else begin
          m_age++;
          if (m_age == DRAIN_TIMEOUT) begin
            m_mode = "FLUSH"; m_rst_left = FLUSH_CYCLES; m_after = "IDLE"; m_hpend = 0;
          end
        end
      end
    end
    if (cnt_clr_i) m_cnt = 0;
    else if (instr_val_i && m_cnt < 65535) m_cnt++;
  endtask

  function automatic logic [31:0] model_exp();
    logic [1:0] ex;
    ex = (m_mode == "RUN") ? 2'd1 : (m_mode == "STEP") ? 2'd2 : 2'd0;
    return pack(ex, m_wen, m_pc, m_mode != "FLUSH", m_mode == "RUN" || m_mode == "STEP",
                m_mode == "HALTED", m_err, 16'(m_cnt));
  endfunction

  typedef struct {
    logic       run, stop, step, ld;
    logic [7:0] addr;
    logic       halt, done, val;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(input logic r, input logic s, input logic st, input logic l,
                              input logic [7:0] a, input logic h, input logic d, input logic v,
                              input logic [1:0] ex, input logic wen, input logic [7:0] pc,
                              input logic rstn, input logic runo, input logic hlt,
                              input logic err, input logic [15:0] cnt);
    vec_t t;
    t.run = r; t.stop = s; t.step = st; t.ld = l; t.addr = a;
    t.halt = h; t.done = d; t.val = v;
    t.exp = pack(ex, wen, pc, rstn, runo, hlt, err, cnt);
    return t;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    int n;

    //          r s st l addr  h d v   ex wen pc  rstn run hlt err cnt
    vecs[0]  = mk(0,0,0,1,8'h20,0,0,0, 0,1,8'h20,1,0,0,0,0);
    vecs[1]  = mk(0,0,0,0,8'h00,0,0,0, 0,0,8'h20,1,0,0,0,0);
    vecs[2]  = mk(1,0,0,0,8'h00,0,0,0, 1,0,8'h20,1,1,0,0,0);
    vecs[3]  = mk(0,0,0,0,8'h00,0,0,1, 1,0,8'h20,1,1,0,0,1);
    vecs[4]  = mk(0,1,0,0,8'h00,0,0,1, 0,0,8'h20,1,0,0,0,2);
    vecs[5]  = mk(0,0,1,0,8'h00,0,0,0, 0,0,8'h20,1,0,0,1,2);
    vecs[6]  = mk(0,0,0,0,8'h00,0,0,1, 0,0,8'h20,1,0,0,0,3);
    vecs[7]  = mk(0,0,0,0,8'h00,0,1,0, 0,0,8'h20,1,0,0,0,3);
    vecs[8]  = mk(0,0,1,0,8'h00,0,0,0, 2,0,8'h20,1,1,0,0,3);
    vecs[9]  = mk(0,0,0,0,8'h00,0,0,0, 0,0,8'h20,1,0,0,0,3);
    vecs[10] = mk(0,0,0,0,8'h00,0,1,0, 0,0,8'h20,1,0,0,0,3);
    vecs[11] = mk(1,1,1,1,8'h55,0,0,0, 0,0,8'h20,1,0,0,0,3);
    vecs[12] = mk(1,0,1,0,8'h00,0,0,0, 2,0,8'h20,1,1,0,0,3);
    vecs[13] = mk(0,0,0,0,8'h00,1,0,0, 0,0,8'h20,1,0,0,0,3);
    vecs[14] = mk(0,0,0,0,8'h00,0,1,0, 0,0,8'h20,1,0,1,0,3);
    vecs[15] = mk(0,0,0,1,8'h3C,0,0,0, 0,1,8'h3C,1,0,1,0,3);
    vecs[16] = mk(0,0,1,0,8'h00,0,0,0, 0,0,8'h3C,0,0,0,0,3);
    vecs[17] = mk(0,0,0,0,8'h00,0,0,0, 2,0,8'h3C,1,1,0,0,3);
    vecs[18] = mk(0,0,0,0,8'h00,0,0,0, 0,0,8'h3C,1,0,0,0,3);
    vecs[19] = mk(0,0,0,0,8'h00,0,1,0, 0,0,8'h3C,1,0,0,0,3);
    vecs[20] = mk(1,0,0,0,8'h00,0,0,0, 1,0,8'h3C,1,1,0,0,3);
    vecs[21] = mk(1,0,0,0,8'h00,0,0,0, 1,0,8'h3C,1,1,0,1,3);
    vecs[22] = mk(0,1,0,0,8'h00,1,0,0, 0,0,8'h3C,1,0,0,0,3);
    vecs[23] = mk(0,0,0,0,8'h00,0,1,0, 0,0,8'h3C,1,0,1,0,3);
    vecs[24] = mk(1,0,0,0,8'h00,0,0,0, 0,0,8'h3C,0,0,0,0,3);
    vecs[25] = mk(0,0,1,0,8'h00,0,0,0, 1,0,8'h3C,1,1,0,1,3);
    vecs[26] = mk(0,1,0,0,8'h00,0,0,0, 0,0,8'h3C,1,0,0,0,3);
    vecs[27] = mk(0,0,0,0,8'h00,0,1,0, 0,0,8'h3C,1,0,0,0,3);
    vecs[28] = mk(0,1,0,0,8'h00,0,0,0, 0,0,8'h3C,1,0,0,0,3);

    // Reset and initial flush length
    clear_inputs();
    arst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_vals", act_vec(), pack(2'd0, 0, PC_RESET, 0, 0, 0, 0, 16'd0));
    arst_ni = 1'b1;
    low = core_rst_no ? 0 : 1;
    for (int i = 0; i < 12 && !core_rst_no; i++) begin
      tick();
      if (!core_rst_no) low++;
    end
    chk("reset_flush_len", 32'(low), 32'd4);
    chk("reset_idle", act_vec(), pack(2'd0, 0, 8'h10, 1, 0, 0, 0, 16'd0));

    // Directed table
    for (int i = 0; i < 29; i++) begin
      run_i = vecs[i].run; stop_i = vecs[i].stop; step_i = vecs[i].step;
      load_pc_i = vecs[i].ld; sw_addr_i = vecs[i].addr; cpu_halt_i = vecs[i].halt;
      cpu_done_i = vecs[i].done; instr_val_i = vecs[i].val;
      tick();
      chk($sformatf("vec[%0d]", i), act_vec(), vecs[i].exp);
    end
    clear_inputs();

    // Stop + drain with retired-instruction pulses
    cnt_clr_i = 1; tick(); cnt_clr_i = 0;
    chk("cnt_clear", 32'(instr_cnt_o), 32'd0);
    run_i = 1; tick(); run_i = 0;
    chk("run_exec", 32'(cpu_exec_o), 32'd1);
    stop_i = 1; tick(); stop_i = 0;
    chk("stop_exec", 32'(cpu_exec_o), 32'd0);
    for (int i = 0; i < 7; i++) begin
      instr_val_i = 1;
      cpu_done_i  = (i == 5);
      tick();
    end
    instr_val_i = 0; cpu_done_i = 0;
    chk("cnt_seven", 32'(instr_cnt_o), 32'd7);
    step_i = 1; tick(); step_i = 0;
    chk("step_exec2", 32'(cpu_exec_o), 32'd2);
    chk("step_no_err", 32'(cmd_err_o), 32'd0);
    tick();
    chk("step_one_cycle", 32'(cpu_exec_o), 32'd0);
    cpu_done_i = 1; tick(); cpu_done_i = 0;

    // Drain timeout forces a full flush
    run_i = 1; tick(); run_i = 0;
    stop_i = 1; tick(); stop_i = 0;
    n = 0;
    while (core_rst_no && n < 100) begin
      tick();
      n++;
    end
    chk("drain_timeout_len", 32'(n), 32'd64);
    low = core_rst_no ? 0 : 1;
    for (int i = 0; i < 20 && !core_rst_no; i++) begin
      tick();
      if (!core_rst_no) low++;
    end
    chk("timeout_flush_len", 32'(low), 32'd4);
    chk("timeout_not_halted", 32'(halted_o), 32'd0);
    step_i = 1; tick(); step_i = 0;
    chk("after_timeout_idle", 32'({cpu_exec_o, cmd_err_o}), 32'({2'd2, 1'b0}));
    cpu_done_i = 1; tick(); cpu_done_i = 0;

    // Counter saturation and clear priority
    cnt_clr_i = 1; tick(); cnt_clr_i = 0;
    instr_val_i = 1;
    repeat (65534) tick();
    chk("cnt_fffe", 32'(instr_cnt_o), 32'hFFFE);
    repeat (3) tick();
    chk("cnt_saturate", 32'(instr_cnt_o), 32'hFFFF);
    cnt_clr_i = 1; tick(); cnt_clr_i = 0;
    chk("clr_beats_inc", 32'(instr_cnt_o), 32'd0);
    tick();
    instr_val_i = 0;
    chk("cnt_after_clr", 32'(instr_cnt_o), 32'd1);

    // Random traffic against the model
    clear_inputs();
    arst_ni = 0; #1;
    model_reset();
    chk("rand_reset", act_vec(), model_exp());
    @(posedge clk_i); #1;
    arst_ni = 1;
    for (int c = 0; c < 3000; c++) begin
      int done_pct;
      done_pct = (((c / 300) % 2) == 1) ? 2 : 25;
      if ($urandom_range(0, 599) == 0) begin
        arst_ni = 0; #1;
        model_reset();
        chk($sformatf("async_rst[%0d]", c), act_vec(), model_exp());
        @(posedge clk_i); #1;
        arst_ni = 1;
      end else begin
        run_i       = ($urandom_range(0, 99) < 6);
        stop_i      = ($urandom_range(0, 99) < 4);
        step_i      = ($urandom_range(0, 99) < 6);
        load_pc_i   = ($urandom_range(0, 99) < 5);
        cnt_clr_i   = ($urandom_range(0, 99) < 1);
        cpu_halt_i  = ($urandom_range(0, 99) < 3);
        cpu_done_i  = ($urandom_range(0, 99) < done_pct);
        instr_val_i = ($urandom_range(0, 99) < 50);
        sw_addr_i   = 8'($urandom);
        model_step();
        tick();
        chk($sformatf("rand[%0d]", c), act_vec(), model_exp());
      end
    end
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
